gen_sequencer: RTL and testbench

Run controller for the generator datapath. It sits between the rising-edge-detected user commands and the Fibonacci/timer generators feeding the dual-clock wrapper buffer. It selects which generator runs, gates its enable on buffer back-pressure, and handles stop requests and optional word-count limits. After a stop it drains the buffer before returning to idle, and it reports mode, progress and completion to the display manager.

---
 rtl/gen_sequencer.sv | 149 ++++++++++++++
 tb/tb_gen_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/gen_sequencer.sv
// Run controller for the Fibonacci/timer generators: it picks the active generator,
// throttles it on buffer back-pressure, counts words, and drains the buffer after a stop.
module gen_sequencer #(
    parameter int CNT_W     = 16,
    parameter int MAX_WORDS = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_f,
    input  logic             start_t,
    input  logic             stop_f_t,
    input  logic             buffer_full,
    input  logic             buffer_empty,
    input  logic             f_valid,
    input  logic             t_valid,
    output logic             f_en,
    output logic             t_en,
    output logic             gen_mod,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] word_count,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COMM_F    = 3'd1,
        S_WAIT_F    = 3'd2,
        S_COMM_T    = 3'd3,
        S_WAIT_T    = 3'd4,
        S_BUF_EMPTY = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_f_en;
    logic               r_t_en;
    logic               r_gen_mod;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_word_count;

    logic               w_sel_valid;
    logic               w_inc;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_limit_hit;
    logic               w_start;

    // Counter datapath: saturating increment on the selected generator's valid
    always_comb begin
        w_sel_valid = r_gen_mod ? t_valid : f_valid;
        w_inc       = (r_state != S_IDLE) && w_sel_valid;
        if (r_word_count == {CNT_W{1'b1}}) begin
            w_cnt_inc = r_word_count;
        end else begin
            w_cnt_inc = r_word_count + CNT_W'(1);
        end
        // The limit looks at the post-increment value so the stop lands on the same edge
        w_limit_hit = (MAX_WORDS != 32'sd0) && w_inc && (w_cnt_inc == CNT_W'(MAX_WORDS));
        w_start     = (r_state == S_IDLE) && (start_f || start_t);
    end

    // Next-state logic
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (start_f) begin
                    w_next = S_COMM_F;
                end else if (start_t) begin
                    w_next = S_COMM_T;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_COMM_F, S_WAIT_F: begin
                if (stop_f_t || w_limit_hit) begin
                    w_next = S_BUF_EMPTY;
                end else if (buffer_full) begin
                    w_next = S_WAIT_F;
                end else begin
                    w_next = S_COMM_F;
                end
            end
            S_COMM_T, S_WAIT_T: begin
                if (stop_f_t || w_limit_hit) begin
                    w_next = S_BUF_EMPTY;
                end else if (buffer_full) begin
                    w_next = S_WAIT_T;
                end else begin
                    w_next = S_COMM_T;
                end
            end
            S_BUF_EMPTY: begin
                if (buffer_empty) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_BUF_EMPTY;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register with outputs decoded from the next state so they stay registered
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_f_en  <= 1'b0;
            r_t_en  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_f_en  <= (w_next == S_COMM_F);
            r_t_en  <= (w_next == S_COMM_T);
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (r_state == S_BUF_EMPTY) && (w_next == S_IDLE);
        end
    end

    // Generator select and word counter; both hold through drain and idle until the next start
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_gen_mod    <= 1'b0;
            r_word_count <= {CNT_W{1'b0}};
        end else if (w_start) begin
            r_gen_mod    <= !start_f;
            r_word_count <= {CNT_W{1'b0}};
        end else if (w_inc) begin
            r_gen_mod    <= r_gen_mod;
            r_word_count <= w_cnt_inc;
        end else begin
            r_gen_mod    <= r_gen_mod;
            r_word_count <= r_word_count;
        end
    end

    assign f_en       = r_f_en;
    assign t_en       = r_t_en;
    assign gen_mod    = r_gen_mod;
    assign busy       = r_busy;
    assign done       = r_done;
    assign word_count = r_word_count;
    assign state      = r_state;

endmodule

// File: tb/tb_gen_sequencer.sv
// Directed bench for gen_sequencer: an unlimited instance and a MAX_WORDS=5 instance
// share the same stimulus; expected values are hand-derived per step.
module tb_gen_sequencer;

    logic        clock;
    logic        reset;
    logic        start_f, start_t, stop_f_t;
    logic        buffer_full, buffer_empty, f_valid, t_valid;

    logic        a_f_en, a_t_en, a_gen_mod, a_busy, a_done;
    logic [15:0] a_count;
    logic [2:0]  a_state;
    logic        b_f_en, b_t_en, b_gen_mod, b_busy, b_done;
    logic [15:0] b_count;
    logic [2:0]  b_state;

    int n_checks = 0;
    int n_fail   = 0;

    gen_sequencer #(.CNT_W(16), .MAX_WORDS(0)) dut (
        .clock(clock), .reset(reset), .start_f(start_f), .start_t(start_t),
        .stop_f_t(stop_f_t), .buffer_full(buffer_full), .buffer_empty(buffer_empty),
        .f_valid(f_valid), .t_valid(t_valid), .f_en(a_f_en), .t_en(a_t_en),
        .gen_mod(a_gen_mod), .busy(a_busy), .done(a_done),
        .word_count(a_count), .state(a_state)
    );

    gen_sequencer #(.CNT_W(16), .MAX_WORDS(5)) dut_lim (
        .clock(clock), .reset(reset), .start_f(start_f), .start_t(start_t),
        .stop_f_t(stop_f_t), .buffer_full(buffer_full), .buffer_empty(buffer_empty),
        .f_valid(f_valid), .t_valid(t_valid), .f_en(b_f_en), .t_en(b_t_en),
        .gen_mod(b_gen_mod), .busy(b_busy), .done(b_done),
        .word_count(b_count), .state(b_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start_f = 1'b0; start_t = 1'b0; stop_f_t = 1'b0;
        buffer_full = 1'b0; buffer_empty = 1'b0; f_valid = 1'b0; t_valid = 1'b0;
        step(); step();
        chk("rst_state", a_state, 0);
        chk("rst_f_en", a_f_en, 0);
        chk("rst_t_en", a_t_en, 0);
        chk("rst_gen_mod", a_gen_mod, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_count", a_count, 0);
        reset = 1'b1;
        step();

        // Fibonacci run, f_valid every cycle
        start_f = 1'b1; f_valid = 1'b1;
        step();
        start_f = 1'b0;
        chk("f_start_state", a_state, 1);
        chk("f_start_f_en", a_f_en, 1);
        chk("f_start_t_en", a_t_en, 0);
        chk("f_start_gen_mod", a_gen_mod, 0);
        chk("f_start_busy", a_busy, 1);
        chk("f_start_count", a_count, 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("f_ramp_count", a_count, i);
            chk("lim_ramp_count", b_count, i);
            chk("lim_state", b_state, (i == 5) ? 5 : 1);
        end
        chk("lim_f_en_off", b_f_en, 0);
        chk("unlim_state", a_state, 1);

        // Back-pressure for 4 cycles
        f_valid = 1'b0; buffer_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_state", a_state, 2);
            chk("bp_f_en", a_f_en, 0);
            chk("bp_count", a_count, 5);
            chk("lim_no_sixth", b_count, 5);
        end
        buffer_full = 1'b0;
        step();
        chk("bp_resume_state", a_state, 1);
        chk("bp_resume_f_en", a_f_en, 1);
        chk("bp_resume_count", a_count, 5);

        // Stop with buffer already empty: one-cycle drain
        stop_f_t = 1'b1; buffer_empty = 1'b1;
        step();
        stop_f_t = 1'b0;
        chk("stop_state", a_state, 5);
        chk("stop_f_en", a_f_en, 0);
        chk("stop_busy", a_busy, 1);
        chk("lim_done_state", b_state, 0);
        chk("lim_done", b_done, 1);
        chk("lim_busy", b_busy, 0);
        step();
        chk("drain_state", a_state, 0);
        chk("drain_done", a_done, 1);
        chk("drain_busy", a_busy, 0);
        chk("drain_count", a_count, 5);
        chk("lim_done_pulse", b_done, 0);
        step();
        chk("done_one_cycle", a_done, 0);
        buffer_empty = 1'b0;

        // Timer run with stop and 3-cycle drain; f_valid is the unselected valid here
        start_t = 1'b1;
        step();
        start_t = 1'b0;
        chk("t_start_state", a_state, 3);
        chk("t_start_t_en", a_t_en, 1);
        chk("t_start_f_en", a_f_en, 0);
        chk("t_start_gen_mod", a_gen_mod, 1);
        chk("t_start_count", a_count, 0);
        t_valid = 1'b1; f_valid = 1'b1;
        step();
        chk("t_count1", a_count, 1);
        step();
        chk("t_count2", a_count, 2);
        t_valid = 1'b0; f_valid = 1'b0; stop_f_t = 1'b1;
        step();
        stop_f_t = 1'b0;
        chk("t_stop_state", a_state, 5);
        chk("t_stop_t_en", a_t_en, 0);
        step();
        chk("t_drain2_state", a_state, 5);
        step();
        chk("t_drain3_state", a_state, 5);
        chk("t_drain3_done", a_done, 0);
        buffer_empty = 1'b1;
        step();
        chk("t_idle_state", a_state, 0);
        chk("t_idle_done", a_done, 1);
        chk("t_idle_busy", a_busy, 0);
        chk("t_idle_gen_mod", a_gen_mod, 1);
        chk("t_idle_count", a_count, 2);
        step();
        chk("t_done_pulse", a_done, 0);
        chk("t_gen_mod_hold", a_gen_mod, 1);
        buffer_empty = 1'b0;

        // Simultaneous starts: Fibonacci wins; later start_t and t_valid ignored
        start_f = 1'b1; start_t = 1'b1;
        step();
        start_f = 1'b0;
        chk("both_state", a_state, 1);
        chk("both_gen_mod", a_gen_mod, 0);
        chk("both_t_en", a_t_en, 0);
        chk("both_count", a_count, 0);
        t_valid = 1'b1;
        step();
        start_t = 1'b0;
        chk("late_t_state", a_state, 1);
        chk("late_t_t_en", a_t_en, 0);
        chk("late_t_count", a_count, 0);
        step();
        chk("t_valid_ignored", a_count, 0);
        t_valid = 1'b0; f_valid = 1'b1;
        step();
        chk("f_valid_counts", a_count, 1);
        f_valid = 1'b0; stop_f_t = 1'b1; buffer_empty = 1'b1;
        step();
        stop_f_t = 1'b0;
        chk("both_stop_state", a_state, 5);
        step();
        chk("both_idle_done", a_done, 1);
        buffer_empty = 1'b0;
        step();

        // Reset during WAIT_T with 9 words counted
        start_t = 1'b1;
        step();
        start_t = 1'b0;
        t_valid = 1'b1;
        repeat (9) step();
        chk("pre_rst_count", a_count, 9);
        t_valid = 1'b0; buffer_full = 1'b1;
        step();
        chk("wait_t_state", a_state, 4);
        chk("wait_t_t_en", a_t_en, 0);
        chk("wait_t_count", a_count, 9);
        #2 reset = 1'b0;
        #1;
        chk("async_state", a_state, 0);
        chk("async_t_en", a_t_en, 0);
        chk("async_gen_mod", a_gen_mod, 0);
        chk("async_busy", a_busy, 0);
        chk("async_count", a_count, 0);
        chk("async_lim_state", b_state, 0);
        step(); step();
        chk("rst_no_done", a_done, 0);
        buffer_full = 1'b0; reset = 1'b1;
        step();
        start_t = 1'b1;
        step();
        start_t = 1'b0;
        chk("post_rst_state", a_state, 3);
        chk("post_rst_t_en", a_t_en, 1);
        chk("post_rst_gen_mod", a_gen_mod, 1);
        chk("post_rst_count", a_count, 0);
        chk("post_rst_done", a_done, 0);
        t_valid = 1'b1;
        step();
        chk("post_rst_count1", a_count, 1);
        t_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
